// File: rtl/div20_pkg.sv
// Shared widths and tag payload for the divide-by-20 arbiter slice.
package div20_pkg;

  localparam int unsigned DIV_IN_W  = 37;
  localparam int unsigned DIV_OUT_W = 32;
  localparam int unsigned DIV_LAT   = 1;

  // Wide enough for the largest supported requester count (8).
  localparam int unsigned TAG_ID_W  = 3;

  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority one-hot grant with a pointer that moves past each winner.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req_valid,
  output logic [N_REQ-1:0]  grant,
  output logic [ID_W-1:0]   grant_id,
  output logic              grant_valid
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;

  // Search from the pointer upward, wrapping, and grant the first valid requester.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      idx = ID_W'((int'(ptr) + i) % int'(N_REQ));
      if (!grant_valid && req_valid[idx]) begin
        grant[idx]  = 1'b1;
        grant_id    = idx;
        grant_valid = 1'b1;
      end
    end
  end

  // Pointer advances to the slot after the winner; holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (grant_valid) begin
      if (grant_id == ID_W'(N_REQ - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= grant_id + ID_W'(1);
      end
    end
  end

endmodule

// File: rtl/div20_arbiter.sv
// Shares one pipelined divide-by-20 unit between N_REQ requesters with tagged results.
module div20_arbiter
  import div20_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned DIV_LAT = div20_pkg::DIV_LAT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DIV_IN_W-1:0] req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DIV_IN_W-1:0]       div_in,
  input  logic [DIV_OUT_W-1:0]      div_out,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DIV_OUT_W-1:0]      rsp_data,
  output logic                      busy
);

  localparam int unsigned LAST = DIV_LAT;

  logic [DIV_IN_W-1:0] ops [N_REQ];
  logic [N_REQ-1:0]    arb_valid;
  logic [ID_W-1:0]     grant_id;
  logic                grant_valid;
  tag_t                tag_in;
  tag_t                tags [DIV_LAT+1];
  logic                busy_next;

  // Unpack the flat operand bus into one word per requester.
  for (genvar g = 0; g < int'(N_REQ); g++) begin : g_ops
    assign ops[g] = req_data[g*DIV_IN_W +: DIV_IN_W];
  end

  // No grants are issued while reset is held.
  assign arb_valid = req_valid & {N_REQ{~reset}};

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (arb_valid),
    .grant       (req_ready),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  // Tag entering the pipeline this cycle, and whether anything will be in flight next cycle.
  always_comb begin
    tag_in    = '0;
    tag_in.v  = grant_valid;
    tag_in.id = TAG_ID_W'(grant_id);
    busy_next = grant_valid;
    for (int s = 0; s <= int'(LAST); s++) begin
      busy_next = busy_next | tags[s].v;
    end
  end

  // Operand register, free-running tag pipeline and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_in    <= '0;
      for (int s = 0; s <= int'(LAST); s++) begin
        tags[s] <= '0;
      end
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      if (grant_valid) begin
        div_in <= ops[grant_id];
      end
      tags[0] <= tag_in;
      for (int s = 1; s <= int'(LAST); s++) begin
        tags[s] <= tags[s-1];
      end
      if (tags[LAST].v) begin
        rsp_valid <= 1'b1;
        rsp_id    <= tags[LAST].id[ID_W-1:0];
        rsp_data  <= div_out;
      end else begin
        rsp_valid <= 1'b0;
      end
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_div20_arbiter.sv
// Directed bench for div20_arbiter paired with a one-stage divide-by-20 model.
module tb_div20_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned IW    = 37;
  localparam int unsigned OW    = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ*IW-1:0]  req_data;
  logic [N_REQ-1:0]     req_ready;
  logic [IW-1:0]        div_in;
  logic [OW-1:0]        div_out;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [OW-1:0]        rsp_data;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  div20_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .DIV_LAT(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .div_in    (div_in),
    .div_out   (div_out),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Divider stand-in: one register stage, signed truncating divide by 20.
  always_ff @(posedge clk) begin
    if (reset) div_out <= '0;
    else       div_out <= 32'($signed(div_in) / 37'sd20);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input logic signed [IW-1:0] v);
    req_data[k*IW +: IW] = v;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      req_valid = '0;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready cyc %0d got %b want 0000", c, req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid cyc %0d got %b want 0", c, rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc %0d got %b want 0", c, busy); end
      checks++; if (div_in !== 37'd0) begin errors++; $display("FAIL reset_div_in cyc %0d got %0h want 0", c, div_in); end
      tick();
    end
  endtask

  task automatic test_single();
    apply_reset();
    req_valid = 4'b0100;
    set_lane(2, 37'sd1310720);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (div_in !== 37'd1310720) begin errors++; $display("FAIL single_div_in got %0d want 1310720", div_in); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_t1 got %b want 1", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_t1 got %b want 0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_t2 got %b want 0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id got %0d want 2", rsp_id); end
    checks++; if (!($signed(rsp_data) >= 65535 && $signed(rsp_data) <= 65537)) begin errors++; $display("FAIL single_rsp_data got %0d want 65536+/-1", $signed(rsp_data)); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop got %b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b want 0", busy); end
  endtask

  task automatic test_all_valid();
    logic [N_REQ-1:0] exp_gnt;
    int exp_id;
    apply_reset();
    for (int k = 0; k < 4; k++) set_lane(k, 37'((k + 1) * 2000));
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) begin
        exp_gnt = 4'b0001 << (c % 4);
        checks++; if (req_ready !== exp_gnt) begin errors++; $display("FAIL all_grant cyc %0d got %b want %b", c, req_ready, exp_gnt); end
      end
      if (c >= 3 && c < 11) begin
        exp_id = (c - 3) % 4;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL all_rsp_valid cyc %0d got %b want 1", c, rsp_valid); end
        checks++; if (rsp_id !== ID_W'(exp_id)) begin errors++; $display("FAIL all_rsp_id cyc %0d got %0d want %0d", c, rsp_id, exp_id); end
        checks++; if (rsp_data !== 32'((exp_id + 1) * 100)) begin errors++; $display("FAIL all_rsp_data cyc %0d got %0d want %0d", c, rsp_data, (exp_id + 1) * 100); end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL all_rsp_idle cyc %0d got %b want 0", c, rsp_valid); end
      end
      tick();
    end
  endtask

  task automatic test_rotate();
    logic [N_REQ-1:0] exp_seq [3];
    exp_seq[0] = 4'b1000;
    exp_seq[1] = 4'b0001;
    exp_seq[2] = 4'b0010;
    apply_reset();
    // One grant to requester 1 leaves the pointer at 2.
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rot_setup got %b want 0010", req_ready); end
    tick();
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'b1011;
      #1;
      checks++; if (req_ready !== exp_seq[c]) begin errors++; $display("FAIL rot_grant step %0d got %b want %b", c, req_ready, exp_seq[c]); end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_reset_flush();
    apply_reset();
    set_lane(0, 37'sd400);
    set_lane(1, 37'sd800);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_pre got %b want 1", busy); end
    tick();
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL flush_ready_in_reset got %b want 0000", req_ready); end
    tick();
    reset = 1'b0;
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_rsp_t3 got %b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_t3 got %b want 0", busy); end
    tick();
    req_valid = 4'b1111;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_rsp_t4 got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL flush_ptr got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_negative();
    apply_reset();
    set_lane(1, -37'sd26214400);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL neg_ready got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL neg_rsp_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL neg_rsp_id got %0d want 1", rsp_id); end
    checks++; if (!($signed(rsp_data) >= -1310721 && $signed(rsp_data) <= -1310719)) begin errors++; $display("FAIL neg_rsp_data got %0d want -1310720+/-1", $signed(rsp_data)); end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_all_valid();
    test_rotate();
    test_reset_flush();
    test_negative();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
